// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types for the multi-cycle sequential ALU.
//   alu_op_e    : 4-bit opcode carried on OP.
//   alu_state_e : IDLE -> BUSY -> DONE handshake sequencer states.
//   iter_mode_e : what the iterative unit does on each BUSY cycle.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    CEQ   = 4'd2,
    CLT   = 4'd3,
    PASSA = 4'd4,
    PASSB = 4'd5,
    SHL   = 4'd6,
    SHR   = 4'd7,
    MUL   = 4'd8,
    BR0   = 4'd9,
    BR1   = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // IT_NONE covers every single-step op and a zero-distance shift.
  typedef enum logic [1:0] {
    IT_NONE = 2'd0,
    IT_SHL  = 2'd1,
    IT_SHR  = 2'd2,
    IT_MUL  = 2'd3
  } iter_mode_e;

endpackage

// File: rtl/seq_alu_iter.sv
// alu_iter_unit: one shift step or one shift-add multiply step per BUSY cycle.
// Optional feature macro: SEQ_ALU_MUL_EN (builds the multiplicand/high-half path).
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : latch mode, initial accumulator, count (and multiplicand)
//   i_busy         : FSM is in BUSY; advances the count and, per mode, the data
//   i_mode         : iteration mode for this op
//   i_init         : initial accumulator (A for shifts, B for multiply)
//   i_mcand        : multiplicand (A), multiply build only
//   i_cnt          : remaining BUSY cycles after the first
//   i_fill         : bit shifted into the vacated position (architectural FLAG)
//   o_cnt_zero     : count has reached zero, this BUSY cycle is the last
//   o_acc_nxt      : accumulator value after this cycle's step
//   o_hi_nxt       : product high half after this cycle's step, multiply build only
//   o_sout         : bit shifted out by this cycle's step
module alu_iter_unit
  import seq_alu_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = $clog2(W) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_busy,
  input  iter_mode_e    i_mode,
  input  logic [W-1:0]  i_init,
`ifdef SEQ_ALU_MUL_EN
  input  logic [W-1:0]  i_mcand,
  output logic [W-1:0]  o_hi_nxt,
`endif
  input  logic [SW-1:0] i_cnt,
  input  logic          i_fill,
  output logic          o_cnt_zero,
  output logic [W-1:0]  o_acc_nxt,
  output logic          o_sout
);

  iter_mode_e    r_mode;
  logic [W-1:0]  r_acc;
  logic [SW-1:0] r_cnt;
  logic [W-1:0]  w_acc_nxt;
  logic          w_sout;
`ifdef SEQ_ALU_MUL_EN
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_mcand;
  logic [W-1:0]  w_hi_nxt;
  logic [W:0]    w_sum;
`endif

  always_comb begin
    w_acc_nxt = r_acc;
    w_sout    = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    w_hi_nxt  = r_hi;
    w_sum     = '0;
`endif
    if (i_busy) begin
      case (r_mode)
        IT_SHL: begin
          w_acc_nxt = {r_acc[W-2:0], i_fill};
          w_sout    = r_acc[W-1];
        end
        IT_SHR: begin
          w_acc_nxt = {i_fill, r_acc[W-1:1]};
          w_sout    = r_acc[0];
        end
`ifdef SEQ_ALU_MUL_EN
        // Multiplier bits drain out of acc LSB-first while product bits
        // fill in from the top; after W steps {hi,acc} is the full product.
        IT_MUL: begin
          w_sum = {1'b0, r_hi} + (r_acc[0] ? {1'b0, r_mcand} : '0);
          {w_hi_nxt, w_acc_nxt} = {w_sum, r_acc[W-1:1]};
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode  <= IT_NONE;
      r_acc   <= '0;
      r_cnt   <= '0;
`ifdef SEQ_ALU_MUL_EN
      r_hi    <= '0;
      r_mcand <= '0;
`endif
    end else if (i_load) begin
      r_mode  <= i_mode;
      r_acc   <= i_init;
      r_cnt   <= i_cnt;
`ifdef SEQ_ALU_MUL_EN
      r_hi    <= '0;
      r_mcand <= i_mcand;
`endif
    end else if (i_busy) begin
      r_acc <= w_acc_nxt;
`ifdef SEQ_ALU_MUL_EN
      r_hi  <= w_hi_nxt;
`endif
      if (r_cnt != '0) r_cnt <= r_cnt - SW'(1);
    end
  end

  assign o_cnt_zero = (r_cnt == '0);
  assign o_acc_nxt  = w_acc_nxt;
  assign o_sout     = w_sout;
`ifdef SEQ_ALU_MUL_EN
  assign o_hi_nxt   = w_hi_nxt;
`endif

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with internal FLAG/OVERFLOW registers, behind
// valid/ready handshakes. Optional feature macro: SEQ_ALU_MUL_EN (iterative
// unsigned multiply; when undefined MUL is an undefined opcode, OUT_HI=0).
// Ports:
//   CLK, RESET_N        : clock, async active-low reset
//   IN_VALID / IN_READY : request handshake (ready only in IDLE)
//   OP, INPUTA, INPUTB  : opcode and operands, sampled on accept
//   OUT_VALID/OUT_READY : result handshake (valid only in DONE)
//   OUT, OUT_HI         : result, product high half
//   FLAG, OVERFLOW      : architectural flag and carry/borrow/shift-out
//   BRANCH_EN           : branch decision, valid with OUT_VALID
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = $clog2(W) + 1
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [3:0]   OP,
  input  logic [W-1:0] INPUTA,
  input  logic [W-1:0] INPUTB,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] OUT,
  output logic [W-1:0] OUT_HI,
  output logic         FLAG,
  output logic         OVERFLOW,
  output logic         BRANCH_EN
);

  alu_state_e    r_state;
  alu_op_e       r_op;
  logic [W-1:0]  r_a, r_b, r_out;
  logic          r_flag, r_ovf, r_br, r_nz;

  logic          w_accept;
  alu_op_e       w_op;
  logic [SW-1:0] w_n, w_cnt;
  iter_mode_e    w_mode;
  logic [W-1:0]  w_init;
  logic          w_cnt_zero, w_sout;
  logic [W-1:0]  w_acc_nxt, w_res;
  logic          w_f, w_c, w_br;
`ifdef SEQ_ALU_MUL_EN
  logic [W-1:0]  r_out_hi, w_hi_nxt, w_hi;
`endif

  assign w_accept = IN_VALID && (r_state == IDLE);
  assign w_op     = alu_op_e'(OP);

  // Accept-time decode: shift distance clamps to W, count is cycles-1.
  always_comb begin
    w_n    = (INPUTB[SW-1:0] > SW'(W)) ? SW'(W) : INPUTB[SW-1:0];
    w_cnt  = '0;
    w_mode = IT_NONE;
    w_init = INPUTA;
    case (w_op)
      SHL: if (w_n != '0) begin w_cnt = w_n - SW'(1); w_mode = IT_SHL; end
      SHR: if (w_n != '0) begin w_cnt = w_n - SW'(1); w_mode = IT_SHR; end
`ifdef SEQ_ALU_MUL_EN
      MUL: begin w_cnt = SW'(W - 1); w_mode = IT_MUL; w_init = INPUTB; end
`endif
      default: ;
    endcase
  end

  alu_iter_unit #(.W(W), .SW(SW)) u_iter (
    .i_clk      (CLK),
    .i_rst_n    (RESET_N),
    .i_load     (w_accept),
    .i_busy     (r_state == BUSY),
    .i_mode     (w_mode),
    .i_init     (w_init),
`ifdef SEQ_ALU_MUL_EN
    .i_mcand    (INPUTA),
    .o_hi_nxt   (w_hi_nxt),
`endif
    .i_cnt      (w_cnt),
    .i_fill     (r_flag),
    .o_cnt_zero (w_cnt_zero),
    .o_acc_nxt  (w_acc_nxt),
    .o_sout     (w_sout)
  );

  // Completion values, committed on the BUSY->DONE edge.
  always_comb begin
    w_res = '0;
    w_f   = r_flag;
    w_c   = r_ovf;
    w_br  = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    w_hi  = '0;
`endif
    case (r_op)
      ADD:   {w_c, w_res} = {1'b0, r_a} + {1'b0, r_b} + {{W{1'b0}}, r_ovf};
      // W+1-bit difference goes negative exactly when A < B+C: top bit is borrow.
      SUB:   {w_c, w_res} = {1'b0, r_a} - {1'b0, r_b} - {{W{1'b0}}, r_ovf};
      CEQ:   begin w_f = (r_a == r_b); w_c = 1'b0; end
      CLT:   begin w_f = (r_a < r_b);  w_c = 1'b0; end
      PASSA: begin w_res = r_a; w_c = 1'b0; end
      PASSB: begin w_res = r_b; w_c = 1'b0; end
      SHL, SHR: begin
        w_res = w_acc_nxt;
        if (r_nz) w_c = w_sout;
      end
`ifdef SEQ_ALU_MUL_EN
      MUL:   begin w_res = w_acc_nxt; w_hi = w_hi_nxt; w_c = |w_hi_nxt; end
`endif
      BR0:   w_br = ~r_flag;
      BR1:   w_br = r_flag;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_op     <= ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_nz     <= 1'b0;
      r_out    <= '0;
      r_flag   <= 1'b0;
      r_ovf    <= 1'b0;
      r_br     <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      r_out_hi <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_op    <= w_op;
          r_a     <= INPUTA;
          r_b     <= INPUTB;
          r_nz    <= (w_n != '0);
          r_state <= BUSY;
        end
        BUSY: if (w_cnt_zero) begin
          r_out    <= w_res;
          r_flag   <= w_f;
          r_ovf    <= w_c;
          r_br     <= w_br;
`ifdef SEQ_ALU_MUL_EN
          r_out_hi <= w_hi;
`endif
          r_state  <= DONE;
        end
        DONE: if (OUT_READY) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign IN_READY  = (r_state == IDLE);
  assign OUT_VALID = (r_state == DONE);
  assign OUT       = r_out;
  assign FLAG      = r_flag;
  assign OVERFLOW  = r_ovf;
  assign BRANCH_EN = r_br;
`ifdef SEQ_ALU_MUL_EN
  assign OUT_HI    = r_out_hi;
`else
  assign OUT_HI    = '0;
`endif

endmodule
